// File: rtl/ahb_rtl_pkg.sv
// Shared encodings and helpers for the AHB-Lite SRAM slave.
// Transfer/size/response codes, FSM states and byte-lane enables.
package ahb_rtl_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SZ_BYTE = 3'd0,
        SZ_HALF = 3'd1,
        SZ_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } state_e;

    // Little-endian lane enables for an aligned transfer
    function automatic logic [3:0] byte_en(
        input logic [1:0] addr,
        input logic [2:0] size
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr;
            SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// Word-organised SRAM with per-byte write enables.
// Writes on the rising clock edge, reads are asynchronous.
module ahb_sram_core #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM slave with programmable wait states and a
// two-cycle ERROR response for out-of-range or misaligned beats.
module ahb_slave_mem
    import ahb_rtl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int unsigned BYTE_AW = $clog2(MEM_BYTES);
    localparam int unsigned WORDS   = MEM_BYTES / 4;
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    state_e               state_q, state_d;
    logic [BYTE_AW-1:0]   addr_q, addr_d;
    logic                 write_q, write_d;
    logic [2:0]           size_q, size_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic                 hreadyout_q, hreadyout_d;
    logic                 hresp_q, hresp_d;

    logic                 sample;
    logic                 valid;
    logic                 bad;
    logic                 mem_we;
    logic [31:0]          mem_rdata;
    logic                 unused_burst;

    assign unused_burst = ^HBURST;

    assign sample = (state_q == IDLE) || (state_q == DATA)
                 || (state_q == ERR2);
    assign valid  = sample & HSEL & HREADY & HTRANS[1];

    // Power-of-2 memory: any set bit above the index means out of range
    always_comb begin
        bad = 1'b0;
        if (|HADDR[ADDR_W-1:BYTE_AW])
            bad = 1'b1;
        if (HSIZE > SZ_WORD)
            bad = 1'b1;
        if (HSIZE == SZ_HALF && HADDR[0])
            bad = 1'b1;
        if (HSIZE == SZ_WORD && |HADDR[1:0])
            bad = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wcnt_d  = wcnt_q;
        if (valid) begin
            addr_d  = HADDR[BYTE_AW-1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            if (bad) begin
                state_d = ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = WAIT;
                wcnt_d  = WS - 4'd1;
            end else begin
                state_d = DATA;
            end
        end else begin
            unique case (state_q)
                WAIT: begin
                    if (wcnt_q == 4'd0)
                        state_d = DATA;
                    else
                        wcnt_d = wcnt_q - 4'd1;
                end
                ERR1:    state_d = ERR2;
                default: state_d = IDLE;
            endcase
        end
    end

    assign hreadyout_d = !((state_d == WAIT) || (state_d == ERR1));
    assign hresp_d     = (state_d == ERR1) || (state_d == ERR2);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            wcnt_q      <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            wcnt_q      <= wcnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign mem_we = (state_q == DATA) && write_q;

    ahb_sram_core #(
        .DEPTH (WORDS)
    ) u_core (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (byte_en(addr_q[1:0], size_q)),
        .addr_i  (addr_q[BYTE_AW-1:2]),
        .wdata_i (HWDATA),
        .rdata_o (mem_rdata)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = ((state_q == DATA) && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: two instances (0 and 3 wait states) behind
// a tiny mux, checked against a byte-array model of the memory.
module tb_ahb_slave_mem;

    localparam int MEMB = 1024;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        sel = 1'b0;

    logic        ro0, rs0, ro1, rs1;
    logic [31:0] rd0, rd1;
    logic        hready, bresp;
    logic [31:0] brdata;

    assign hready = sel ? ro1 : ro0;
    assign bresp  = sel ? rs1 : rs0;
    assign brdata = sel ? rd1 : rd0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~sel),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro0), .HRESP(rs0),
        .HRDATA(rd0)
    );

    ahb_slave_mem #(.WAIT_STATES(3)) u1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & sel),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro1), .HRESP(rs1),
        .HRDATA(rd1)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mdl [2][MEMB];
    logic        t_wr [256];
    logic [31:0] t_ad [256];
    logic [2:0]  t_sz [256];
    logic [31:0] t_wd [256];
    logic [1:0]  t_tr [256];
    logic [31:0] r_data [256];

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a,
                                  input logic [2:0] sz);
        if (a >= MEMB) return 1'b1;
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] mread(input int s, input int a);
        int b;
        b = a - (a % 4);
        return {mdl[s][b+3], mdl[s][b+2], mdl[s][b+1], mdl[s][b]};
    endfunction

    task automatic mwrite(input int s, input int a, input int sz,
                          input logic [31:0] wd);
        int lane;
        for (int k = 0; k < (1 << sz); k++) begin
            lane = (a + k) % 4;
            mdl[s][a + k] = wd[8*lane +: 8];
        end
    endtask

    task automatic check_beat(input int i, input int waits,
                              input logic lowresp, input logic resp,
                              input logic [31:0] rdata);
        int s;
        s = sel ? 1 : 0;
        r_data[i] = rdata;
        if (is_err(t_ad[i], t_sz[i])) begin
            chk($sformatf("err_waits@%h", t_ad[i]), waits, 1);
            chk($sformatf("err_resp@%h", t_ad[i]),
                {30'd0, lowresp, resp}, 32'd3);
            chk($sformatf("err_rdata@%h", t_ad[i]), rdata, 0);
        end else begin
            chk($sformatf("ok_waits@%h", t_ad[i]), waits, sel ? 3 : 0);
            chk($sformatf("ok_resp@%h", t_ad[i]),
                {30'd0, lowresp, resp}, 32'd0);
            if (t_wr[i]) begin
                chk($sformatf("wr_rdata@%h", t_ad[i]), rdata, 0);
                mwrite(s, int'(t_ad[i]), int'(t_sz[i]), t_wd[i]);
            end else begin
                chk($sformatf("rd_rdata@%h", t_ad[i]), rdata,
                    mread(s, int'(t_ad[i])));
            end
        end
    endtask

    // Pipelined master: address of beat ap overlaps data of beat dp
    task automatic run_seq(input int n);
        int ap, dp, waits, guard;
        logic lowresp;
        ap = 0; dp = -1; waits = 0; guard = 0; lowresp = 1'b0;
        while ((ap < n || dp >= 0) && guard < LIMIT) begin
            if (ap < n) begin
                hsel = 1'b1; haddr = t_ad[ap]; htrans = t_tr[ap];
                hwrite = t_wr[ap]; hsize = t_sz[ap];
            end else begin
                hsel = 1'b0; haddr = '0; htrans = 2'd0;
                hwrite = 1'b0; hsize = 3'd0;
            end
            hwdata = (dp >= 0) ? t_wd[dp] : 32'h0;
            @(negedge clk);
            if (hready) begin
                if (dp >= 0)
                    check_beat(dp, waits, lowresp, bresp, brdata);
                waits = 0;
                lowresp = 1'b0;
                dp = (ap < n) ? ap : -1;
                if (ap < n) ap++;
            end else begin
                waits++;
                lowresp = lowresp | bresp;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        chk("seq_timeout", {31'd0, guard >= LIMIT}, 0);
    endtask

    task automatic set_t(input int i, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        t_wr[i] = wr; t_ad[i] = a; t_sz[i] = sz; t_wd[i] = wd;
        t_tr[i] = 2'd2;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 256; i++)
            set_t(i, 1'b1, 32'(i * 4), 3'd2, $urandom);
        run_seq(256);
    endtask

    task automatic rand_seq(input int n);
        logic [31:0] a;
        logic [2:0] sz;
        for (int i = 0; i < n; i++) begin
            sz = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                a = 32'(MEMB + $urandom_range(0, 4095));
            else if (i > 0 && $urandom_range(0, 3) == 0)
                a = t_ad[i-1];
            else
                a = 32'($urandom_range(0, MEMB - 1));
            if ($urandom_range(0, 3) != 0 && sz <= 3'd2)
                a = a & ~((32'd1 << sz) - 1);
            set_t(i, 1'($urandom), a, sz, $urandom);
        end
        run_seq(n);
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", {31'd0, ro0}, 1);
        chk("rst_resp0", {31'd0, rs0}, 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_ready1", {31'd0, ro1}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        sel = 1'b0;
        fill_all();

        set_t(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        set_t(1, 1'b0, 32'h10, 3'd2, 32'h0);
        run_seq(2);
        chk("t2_word", r_data[1], 32'hDEADBEEF);

        set_t(0, 1'b1, 32'h20, 3'd0, 32'h00000011);
        set_t(1, 1'b1, 32'h21, 3'd0, 32'h00002200);
        set_t(2, 1'b1, 32'h22, 3'd1, 32'h44330000);
        set_t(3, 1'b0, 32'h20, 3'd2, 32'h0);
        run_seq(4);
        chk("t3_word", r_data[3], 32'h44332211);

        set_t(0, 1'b0, 32'h400, 3'd2, 32'h0);
        set_t(1, 1'b1, 32'h06, 3'd2, 32'hCAFEF00D);
        set_t(2, 1'b0, 32'h04, 3'd2, 32'h0);
        run_seq(3);

        @(negedge clk);
        chk("idle_ready", {31'd0, hready}, 1);
        chk("idle_resp", {31'd0, bresp}, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++)
            rand_seq(40);

        sel = 1'b1;
        fill_all();

        hburst = 3'd3;
        for (int i = 0; i < 4; i++) begin
            set_t(i, 1'b0, 32'(i * 4), 3'd2, 32'h0);
            t_tr[i] = (i == 0) ? 2'd2 : 2'd3;
        end
        run_seq(4);
        hburst = 3'd0;

        // Reset lands while the write sits in its wait states
        hsel = 1'b1; haddr = 32'h30; htrans = 2'd2;
        hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h12345678;
        @(negedge clk);
        chk("mid_wait_low", {31'd0, ro1}, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ro1}, 1);
        chk("mid_rst_resp", {31'd0, rs1}, 0);
        chk("mid_rst_rdata", rd1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_t(0, 1'b0, 32'h30, 3'd2, 32'h0);
        run_seq(1);

        for (int k = 0; k < 4; k++)
            rand_seq(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
